// File: rtl/dac_segment_encoder_pkg.sv
// rtl/dac_segment_encoder_pkg.sv - shared constants, types and bit mapping for the segmented DAC encoder
package dac_enc_pkg;

    localparam int N_THERM      = 17;
    localparam int N_BIN        = 6;
    localparam int CODE_W       = 11;
    localparam int CODE_MAX     = 1151;
    localparam int CAL_IDX_BIN0 = 17;
    localparam int CAL_IDX_RED  = 18;
    localparam int CAL_IDX_MAX  = 23;

    typedef logic [N_THERM-1:0] therm_t;
    typedef logic [N_BIN:0]     bin_t;

    // Binary cells: [0]=bin0, [1]=redundant bin0 (idle), [2..6]=bin1..bin5.
    function automatic bin_t bin_map(input logic [N_BIN-1:0] lsb);
        return {lsb[N_BIN-1:1], 1'b0, lsb[0]};
    endfunction

endpackage

// File: rtl/dac_segment_encoder_if.sv
// rtl/dac_segment_encoder_if.sv - sample/calibration inputs and per-cell data outputs of the encoder
interface dac_segment_encoder_if;
    import dac_enc_pkg::*;

    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              dwa_ena;
    logic              cal_ena;
    logic [4:0]        cal_sel;

    therm_t            datatherm;
    therm_t            datathermb;
    bin_t              databin;
    bin_t              databinb;
    logic [4:0]        cal_idx;
    logic              cal_active;
    logic              cal_err;
    logic              sat;

    modport master (
        output code_in, code_valid, dwa_ena, cal_ena, cal_sel,
        input  datatherm, datathermb, databin, databinb,
        input  cal_idx, cal_active, cal_err, sat
    );

    modport slave (
        input  code_in, code_valid, dwa_ena, cal_ena, cal_sel,
        output datatherm, datathermb, databin, databinb,
        output cal_idx, cal_active, cal_err, sat
    );

endinterface

// File: rtl/dac_segment_encoder_segment_rotator.sv
// rtl/dac_segment_encoder_segment_rotator.sv - mod-17 rotation of an n-unit unary mask starting at ptr
module segment_rotator
    import dac_enc_pkg::*;
(
    input  logic [4:0] n,
    input  logic [4:0] ptr,
    output therm_t     rotated
);

    int off;

    // Unit i is on when its distance from ptr, walking upward mod N_THERM, is below n.
    always_comb begin
        rotated = '0;
        off     = 0;
        for (int i = 0; i < N_THERM; i++) begin
            off = i - int'(ptr);
            if (off < 0) begin
                off = off + N_THERM;
            end
            rotated[i] = (off < int'(n));
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// rtl/dac_segment_encoder.sv - two-stage thermometer/binary encoder with DWA rotation and cell calibration
module dac_segment_encoder
    import dac_enc_pkg::*;
(
    input  logic                 clkin,
    input  logic                 rstb,
    input  logic                 pdb,
    dac_segment_encoder_if.slave bus
);

    logic              over;
    logic [CODE_W-1:0] code_c;

    logic              s1_valid;
    logic              s1_sat;
    logic              s1_dwa;
    logic [4:0]        s1_n;
    logic [N_BIN-1:0]  s1_lsb;
    logic              s1_cal_ena;
    logic [4:0]        s1_cal_sel;

    therm_t            raw_therm, raw_therm_nxt;
    bin_t              raw_bin, raw_bin_nxt;
    logic [4:0]        ptr, ptr_nxt, ptr_adv, rot_ptr;
    logic [5:0]        ptr_sum;
    logic              sat_q, sat_nxt;
    therm_t            rotated;

    logic              cal_ok, cal_bad;
    therm_t            therm_mask;
    bin_t              bin_mask;

    therm_t            therm_q, thermb_q;
    bin_t              bin_q, binb_q;
    logic [4:0]        cal_idx_q;
    logic              cal_active_q, cal_err_q;

    assign over   = bus.code_in > CODE_W'(CODE_MAX);
    assign code_c = over ? CODE_W'(CODE_MAX) : bus.code_in;

    // Calibration select is captured every cycle; the sample fields only on a strobe.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            s1_valid   <= 1'b0;
            s1_sat     <= 1'b0;
            s1_dwa     <= 1'b0;
            s1_n       <= '0;
            s1_lsb     <= '0;
            s1_cal_ena <= 1'b0;
            s1_cal_sel <= '0;
        end else if (!pdb) begin
            s1_valid   <= 1'b0;
            s1_cal_ena <= 1'b0;
            s1_cal_sel <= '0;
        end else begin
            s1_valid   <= bus.code_valid;
            s1_cal_ena <= bus.cal_ena;
            s1_cal_sel <= bus.cal_sel;
            if (bus.code_valid) begin
                s1_n   <= code_c[CODE_W-1:N_BIN];
                s1_lsb <= code_c[N_BIN-1:0];
                s1_sat <= over;
                s1_dwa <= bus.dwa_ena;
            end
        end
    end

    assign rot_ptr = s1_dwa ? ptr : '0;

    segment_rotator u_rotator (
        .n       (s1_n),
        .ptr     (rot_ptr),
        .rotated (rotated)
    );

    // n is at most 17 and ptr at most 16, so one conditional subtract wraps the sum.
    assign ptr_sum = {1'b0, ptr} + {1'b0, s1_n};
    assign ptr_adv = (ptr_sum >= 6'(N_THERM)) ? 5'(ptr_sum - 6'(N_THERM)) : ptr_sum[4:0];

    always_comb begin
        raw_therm_nxt = raw_therm;
        raw_bin_nxt   = raw_bin;
        sat_nxt       = sat_q;
        ptr_nxt       = ptr;
        if (s1_valid) begin
            raw_therm_nxt = rotated;
            raw_bin_nxt   = bin_map(s1_lsb);
            raw_bin_nxt[CAL_IDX_RED-CAL_IDX_BIN0] = 1'b0;
            sat_nxt       = s1_sat;
            ptr_nxt       = s1_dwa ? ptr_adv : '0;
        end
    end

    assign cal_ok  = s1_cal_ena && (s1_cal_sel <= 5'(CAL_IDX_MAX));
    assign cal_bad = s1_cal_ena && (s1_cal_sel > 5'(CAL_IDX_MAX));

    always_comb begin
        therm_mask = '0;
        bin_mask   = '0;
        for (int i = 0; i < N_THERM; i++) begin
            therm_mask[i] = cal_ok && (s1_cal_sel == 5'(i));
        end
        for (int j = 0; j <= N_BIN; j++) begin
            bin_mask[j] = cal_ok && (s1_cal_sel == 5'(CAL_IDX_BIN0 + j));
        end
    end

    // The unmasked data is kept separately so a cell leaving calibration recovers its value.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            raw_therm    <= '0;
            raw_bin      <= '0;
            ptr          <= '0;
            sat_q        <= 1'b0;
            therm_q      <= '0;
            thermb_q     <= '1;
            bin_q        <= '0;
            binb_q       <= '1;
            cal_idx_q    <= '0;
            cal_active_q <= 1'b0;
            cal_err_q    <= 1'b0;
        end else if (!pdb) begin
            raw_therm    <= '0;
            raw_bin      <= '0;
            ptr          <= '0;
            sat_q        <= 1'b0;
            therm_q      <= '0;
            thermb_q     <= '1;
            bin_q        <= '0;
            binb_q       <= '1;
            cal_idx_q    <= '0;
            cal_active_q <= 1'b0;
            cal_err_q    <= 1'b0;
        end else begin
            raw_therm    <= raw_therm_nxt;
            raw_bin      <= raw_bin_nxt;
            ptr          <= ptr_nxt;
            sat_q        <= sat_nxt;
            therm_q      <= raw_therm_nxt & ~therm_mask;
            thermb_q     <= ~raw_therm_nxt & ~therm_mask;
            bin_q        <= raw_bin_nxt & ~bin_mask;
            binb_q       <= ~raw_bin_nxt & ~bin_mask;
            cal_idx_q    <= cal_ok ? s1_cal_sel : '0;
            cal_active_q <= cal_ok;
            cal_err_q    <= cal_bad;
        end
    end

    assign bus.datatherm  = therm_q;
    assign bus.datathermb = thermb_q;
    assign bus.databin    = bin_q;
    assign bus.databinb   = binb_q;
    assign bus.cal_idx    = cal_idx_q;
    assign bus.cal_active = cal_active_q;
    assign bus.cal_err    = cal_err_q;
    assign bus.sat        = sat_q;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// tb/tb_dac_segment_encoder.sv - table vectors, corner sequences and random stimulus against a sample-level model
module tb_dac_segment_encoder;
    import dac_enc_pkg::*;

    logic clkin = 1'b0;
    logic rstb;
    logic pdb;

    dac_segment_encoder_if bus ();

    dac_segment_encoder dut (
        .clkin (clkin),
        .rstb  (rstb),
        .pdb   (pdb),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_errors = 0;

    // Model: sample held one edge, then the visible state after the second edge.
    bit m1_valid, m1_dwa, m1_cal_ena;
    int m1_code, m1_cal_sel;
    int e_therm, e_bin, e_ptr, e_cal_sel;
    bit e_sat, e_cal_ena;

    typedef struct {
        int code;
        bit dwa;
        int exp_therm;
        int exp_bin;
        bit exp_sat;
        int exp_ptr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m1_valid = 0; m1_dwa = 0; m1_cal_ena = 0; m1_code = 0; m1_cal_sel = 0;
        e_therm = 0; e_bin = 0; e_ptr = 0; e_cal_sel = 0; e_sat = 0; e_cal_ena = 0;
    endtask

    task automatic model_edge();
        int c, n, lsb, base;
        if (!pdb) begin
            e_therm = 0; e_bin = 0; e_ptr = 0; e_sat = 0; e_cal_ena = 0;
            m1_valid = 0; m1_cal_ena = 0;
            return;
        end
        if (m1_valid) begin
            c    = (m1_code > CODE_MAX) ? CODE_MAX : m1_code;
            n    = c / 64;
            lsb  = c % 64;
            base = m1_dwa ? e_ptr : 0;
            e_therm = 0;
            for (int i = 0; i < n; i++) e_therm |= 1 << ((base + i) % 17);
            e_bin = (lsb & 1) | ((lsb >> 1) << 2);
            e_sat = (m1_code > CODE_MAX);
            e_ptr = m1_dwa ? (base + n) % 17 : 0;
        end
        e_cal_ena  = m1_cal_ena;
        e_cal_sel  = m1_cal_sel;
        m1_valid   = bus.code_valid;
        m1_code    = int'(bus.code_in);
        m1_dwa     = bus.dwa_ena;
        m1_cal_ena = bus.cal_ena;
        m1_cal_sel = int'(bus.cal_sel);
    endtask

    task automatic compare_all(input string tag);
        bit ok, err;
        int tm, bm;
        ok = e_cal_ena && (e_cal_sel <= 23);
        err = e_cal_ena && (e_cal_sel > 23);
        tm = 0; bm = 0;
        if (ok) begin
            if (e_cal_sel < 17) tm = 1 << e_cal_sel;
            else bm = 1 << (e_cal_sel - 17);
        end
        chk({tag, ".datatherm"},  32'(bus.datatherm),  32'(e_therm & ~tm & 'h1FFFF));
        chk({tag, ".datathermb"}, 32'(bus.datathermb), 32'(~e_therm & ~tm & 'h1FFFF));
        chk({tag, ".databin"},    32'(bus.databin),    32'(e_bin & ~bm & 'h7F));
        chk({tag, ".databinb"},   32'(bus.databinb),   32'(~e_bin & ~bm & 'h7F));
        chk({tag, ".cal_idx"},    32'(bus.cal_idx),    32'(ok ? e_cal_sel : 0));
        chk({tag, ".cal_active"}, 32'(bus.cal_active), 32'(ok));
        chk({tag, ".cal_err"},    32'(bus.cal_err),    32'(err));
        chk({tag, ".sat"},        32'(bus.sat),        32'(e_sat));
        chk({tag, ".ptr"},        32'(dut.ptr),        32'(e_ptr));
    endtask

    task automatic tick();
        @(posedge clkin);
        if (rstb) model_edge();
        #1;
    endtask

    task automatic set_in(input bit valid, input int code, input bit dwa, input bit cena, input int csel);
        bus.code_valid = valid;
        bus.code_in    = 11'(code);
        bus.dwa_ena    = dwa;
        bus.cal_ena    = cena;
        bus.cal_sel    = 5'(csel);
    endtask

    initial begin
        int pick;
        int corners[8];
        corners = '{0, 63, 64, 1087, 1088, 1151, 1152, 2047};

        tbl[0] = '{197,  1'b0, 'h00007, 'h09, 1'b0, 0};
        tbl[1] = '{2000, 1'b0, 'h1FFFF, 'h7D, 1'b1, 0};
        tbl[2] = '{640,  1'b1, 'h003FF, 'h00, 1'b0, 10};
        tbl[3] = '{640,  1'b1, 'h1FC07, 'h00, 1'b0, 3};
        tbl[4] = '{1151, 1'b1, 'h1FFFF, 'h7D, 1'b0, 3};
        tbl[5] = '{0,    1'b1, 'h00000, 'h00, 1'b0, 3};
        tbl[6] = '{1026, 1'b1, 'h1FFFB, 'h04, 1'b0, 2};
        tbl[7] = '{63,   1'b0, 'h00000, 'h7D, 1'b0, 0};
        tbl[8] = '{1152, 1'b0, 'h1FFFF, 'h7D, 1'b1, 0};

        rstb = 1'b0;
        pdb  = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        chk("reset.datathermb", 32'(bus.datathermb), 32'h1FFFF);
        chk("reset.databinb", 32'(bus.databinb), 32'h7F);
        compare_all("reset");
        rstb = 1'b1;

        foreach (tbl[k]) begin
            set_in(1, tbl[k].code, tbl[k].dwa, 0, 0);
            tick();
            set_in(0, 0, tbl[k].dwa, 0, 0);
            tick();
            chk($sformatf("tbl%0d.datatherm", k), 32'(bus.datatherm), 32'(tbl[k].exp_therm));
            chk($sformatf("tbl%0d.datathermb", k), 32'(bus.datathermb), 32'(~tbl[k].exp_therm & 'h1FFFF));
            chk($sformatf("tbl%0d.databin", k), 32'(bus.databin), 32'(tbl[k].exp_bin));
            chk($sformatf("tbl%0d.sat", k), 32'(bus.sat), 32'(tbl[k].exp_sat));
            chk($sformatf("tbl%0d.ptr", k), 32'(dut.ptr), 32'(tbl[k].exp_ptr));
            compare_all($sformatf("tbl%0d", k));
        end

        // Calibration of the redundant cell, then an out-of-range select.
        set_in(1, 63, 0, 1, 18);
        tick();
        set_in(0, 63, 0, 1, 18);
        tick();
        chk("cal18.databin", 32'(bus.databin), 32'h7D);
        chk("cal18.databinb", 32'(bus.databinb), 32'h00);
        chk("cal18.cal_idx", 32'(bus.cal_idx), 32'd18);
        chk("cal18.cal_active", 32'(bus.cal_active), 32'd1);
        compare_all("cal18");
        set_in(0, 0, 0, 1, 30);
        tick();
        tick();
        chk("cal30.cal_err", 32'(bus.cal_err), 32'd1);
        chk("cal30.cal_active", 32'(bus.cal_active), 32'd0);
        chk("cal30.cal_idx", 32'(bus.cal_idx), 32'd0);
        chk("cal30.databinb", 32'(bus.databinb), 32'h02);
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();

        // Hold with code_valid low, then power-down and restart.
        set_in(1, 640, 1, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        tick();
        chk("dwa640.datatherm", 32'(bus.datatherm), 32'h003FF);
        for (int h = 0; h < 5; h++) begin
            tick();
            chk($sformatf("hold%0d.datatherm", h), 32'(bus.datatherm), 32'h003FF);
            chk($sformatf("hold%0d.ptr", h), 32'(dut.ptr), 32'd10);
        end
        pdb = 1'b0;
        tick();
        chk("pdb.datatherm", 32'(bus.datatherm), 32'h0);
        chk("pdb.datathermb", 32'(bus.datathermb), 32'h1FFFF);
        chk("pdb.databinb", 32'(bus.databinb), 32'h7F);
        chk("pdb.ptr", 32'(dut.ptr), 32'd0);
        pdb = 1'b1;
        set_in(1, 640, 0, 0, 0);
        tick();
        chk("pdbup1.datatherm", 32'(bus.datatherm), 32'h0);
        set_in(0, 0, 0, 0, 0);
        tick();
        chk("pdbup2.datatherm", 32'(bus.datatherm), 32'h003FF);

        // Power-down while a sample is in flight discards it.
        set_in(1, 1151, 0, 0, 0);
        tick();
        pdb = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        pdb = 1'b1;
        tick();
        chk("flush.datatherm", 32'(bus.datatherm), 32'h0);
        compare_all("flush");

        // Asynchronous reset in the middle of a stream.
        set_in(1, 2000, 1, 0, 0);
        tick();
        set_in(1, 700, 1, 0, 0);
        tick();
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        chk("arst.datatherm", 32'(bus.datatherm), 32'h0);
        chk("arst.datathermb", 32'(bus.datathermb), 32'h1FFFF);
        chk("arst.databin", 32'(bus.databin), 32'h0);
        chk("arst.databinb", 32'(bus.databinb), 32'h7F);
        chk("arst.ptr", 32'(dut.ptr), 32'd0);
        chk("arst.sat", 32'(bus.sat), 32'd0);
        set_in(0, 0, 0, 0, 0);
        @(negedge clkin);
        rstb = 1'b1;

        for (int r = 0; r < 400; r++) begin
            pdb = ($urandom_range(0, 19) != 0);
            pick = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)]
                                                : int'($urandom_range(0, 2047));
            set_in($urandom_range(0, 9) < 7, pick, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 31)));
            tick();
            compare_all($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
